ripple_counter: RTL and testbench
=================================

RIPPLE_COUNTER -- requirements
Module: ripple_counter

Interface
REQ-001 The block SHALL take one parameter, WIDTH, with default 4; it sets the counter width, legal range 1..32.
REQ-002 The block SHALL have port clk, input, 1 bit; it is the single clock, and all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit; it is the reset.
REQ-004 The block SHALL have port q, output, WIDTH bits; it is the current count, unsigned.
REQ-005 The block SHALL use one clock; reset is synchronous and active-high.
REQ-006 The block SHALL have no other ports, in particular no enable, load or direction input.

Function
REQ-007 The block SHALL be an up-counter: at each rising clk edge with rst=0, q SHALL become q+1 modulo 2^WIDTH.
REQ-008 Increment latency SHALL be one cycle: the new value is visible on q immediately after the clock edge, with no combinational path from any input to q.
REQ-009 The block SHALL implement the count as a chain of WIDTH toggle stages, all clocked by clk.
REQ-010 Stage i SHALL toggle when every stage below it is 1; stage 0 SHALL toggle every cycle. This is ripple-carry toggle logic with no derived clocks.
REQ-011 Wrap-around: from q = 2^WIDTH-1, for example 4'b1111, the next non-reset edge SHALL give q = 0 with no extra cycle or stall.
REQ-012 q SHALL be driven directly from the stage flip-flops (registered output).
REQ-013 q SHALL be exact after every edge: no intermediate or glitch values are visible at the sampled clock edge.
REQ-014 Before the first reset edge, q is unspecified (X in simulation); the block SHALL NOT self-initialise.
REQ-015 rst and clk are the only inputs that affect q.

Reset
REQ-016 When rst=1 at a rising clk edge, q SHALL become 0 at that edge, overriding the increment.
REQ-017 Reset SHALL be sampled only at rising clk edges; rst pulses that fall entirely between edges SHALL have no effect.
REQ-018 While rst is held 1 across consecutive edges, q SHALL stay at 0.
REQ-019 On the first edge with rst=0 after reset, q SHALL become 1.
REQ-020 Reset asserted mid-count (any q, including 2^WIDTH-1) SHALL give q=0 at the next edge, with no wrap or carry effect.

Verification
REQ-021 Power-up then reset: q is X until the first edge with rst=1; after that edge, q=4'b0000.
REQ-022 Counting: release rst, apply 5 edges -> q takes 0001, 0010, 0011, 0100, 0101 in order.
REQ-023 Wrap: from q=4'b1110, apply 3 edges -> q takes 1111, 0000, 0001.
REQ-024 Mid-count reset: at q=4'b0111, hold rst=1 for 2 edges -> q=0000 after each; release rst, apply 1 edge -> q=0001.
REQ-025 Short rst pulse: rst=1 between edges only, deasserted before the next rising edge -> the count continues unaffected.
REQ-026 Full sweep: 16 consecutive edges after reset -> q visits 0..15 once each and returns to 0; repeat the sweep with WIDTH=8 (256 edges).

Source files
------------

// File: rtl/ripple_counter.sv
// Free-running up-counter built from a chain of toggle stages on one clock.
// Stage i flips when all lower stages are 1; synchronous active-high reset clears the count.
module ripple_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_stage;
    logic [WIDTH-1:0] w_toggle;

    // Carry chain: stage 0 always toggles, each higher stage toggles when all below are 1.
    always_comb begin
        w_toggle[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            w_toggle[i] = w_toggle[i-1] & r_stage[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stage <= '0;
        end else begin
            r_stage <= r_stage ^ w_toggle;
        end
    end

    assign q = r_stage;

endmodule

// File: tb/tb_ripple_counter.sv
// Self-checking bench for ripple_counter at WIDTH=4 and WIDTH=8 sharing clk/rst,
// compared against an arithmetic modulo-2^W reference model.
module tb_ripple_counter;

  logic       clk;
  logic       rst;
  logic [3:0] q4;
  logic [7:0] q8;

  int err_cnt;
  int chk_cnt;
  int model4;
  int model8;
  int seen4[16];

  ripple_counter #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .q(q4));
  ripple_counter #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .q(q8));

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // checking task
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // reference model: reset clears, otherwise increment modulo 2^W
  task automatic model_edge(input logic r);
    if (r) begin
      model4 = 0;
      model8 = 0;
    end else begin
      model4 = (model4 + 1) % 16;
      model8 = (model8 + 1) % 256;
    end
  endtask

  // driver: set rst away from the edge, take one rising edge, sample #1 later
  task automatic step(input logic r, input string tag);
    @(negedge clk);
    rst = r;
    @(posedge clk);
    model_edge(r);
    #1;
    check({tag, "_w4"}, {28'd0, q4}, model4[31:0]);
    check({tag, "_w8"}, {24'd0, q8}, model8[31:0]);
  endtask

  // rst pulse that starts and ends strictly between two rising edges
  task automatic short_pulse(input string tag);
    @(negedge clk);
    rst = 1'b0;
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    @(posedge clk);
    model_edge(1'b0);
    #1;
    check({tag, "_w4"}, {28'd0, q4}, model4[31:0]);
    check({tag, "_w8"}, {24'd0, q8}, model8[31:0]);
  endtask

  initial begin
    err_cnt = 0;
    chk_cnt = 0;
    model4  = 0;
    model8  = 0;
    rst     = 1'b1;

    step(1'b1, "reset");
    step(1'b1, "reset_hold");

    for (int i = 0; i < 5; i++) step(1'b0, "count");

    for (int i = 0; i < 16 && model4 != 14; i++) step(1'b0, "to_14");
    check("at_14", {28'd0, q4}, 32'd14);
    for (int i = 0; i < 3; i++) step(1'b0, "wrap");
    check("wrap_end", {28'd0, q4}, 32'd1);

    for (int i = 0; i < 16 && model4 != 7; i++) step(1'b0, "to_7");
    step(1'b1, "mid_rst_a");
    step(1'b1, "mid_rst_b");
    step(1'b0, "mid_release");
    check("mid_release_one", {28'd0, q4}, 32'd1);

    for (int i = 0; i < 4; i++) short_pulse("short_pulse");

    // reset asserted while at all-ones
    for (int i = 0; i < 16 && model4 != 15; i++) step(1'b0, "to_15");
    step(1'b1, "rst_at_max");

    // full sweep: 256 edges covers WIDTH=8 once and WIDTH=4 sixteen times
    foreach (seen4[k]) seen4[k] = 0;
    for (int i = 0; i < 256; i++) begin
      seen4[q4]++;
      step(1'b0, "sweep");
    end
    check("sweep_w4_back_to_0", {28'd0, q4}, 32'd0);
    check("sweep_w8_back_to_0", {24'd0, q8}, 32'd0);
    for (int k = 0; k < 16; k++) check("sweep_visits", seen4[k], 32'd16);

    // random traffic: occasional resets and between-edge pulses
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0:       step(1'b1, "rand_rst");
        1:       short_pulse("rand_pulse");
        default: step(1'b0, "rand_count");
      endcase
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
